axi_lite_wr_bridge: RTL and testbench
=====================================

Name: axi_lite_wr_bridge

Overview:
AXI4-Lite write-slave front end that sits directly upstream of the simulation memory write stage (wen/waddr/wdata/wmask in, wdone out).
- Accepts AW and W channels independently and in either order.
- Validates the strobe pattern.
- Issues exactly one single-cycle write request to the memory write stage, then waits for its done.
- Returns a B-channel response (OKAY or SLVERR) to the LSU/arbiter master.

Parameters:
ADDR_W, 32, address width of AWADDR and mem_waddr
DATA_W, 32, data width of WDATA and mem_wdata
TIMEOUT, 16, max cycles spent in WAIT before SLVERR; 0 disables timeout

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  ADDR_W  write address
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_W  write data
WSTRB  in  4  byte strobes
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response, 2'b00 OKAY, 2'b10 SLVERR
mem_wen  out  1  one-cycle write request to memory write stage
mem_waddr  out  ADDR_W  captured AWADDR
mem_wdata  out  DATA_W  captured WDATA
mem_wmask  out  8  {4'b0, captured WSTRB}
mem_wdone  in  1  write completion from memory write stage (asserted the cycle after mem_wen)

Behaviour:
- Clock and reset:
  - Single clock, ACLK.
  - ARESETn is asynchronous and active-low.
  - While ARESETn=0: state=IDLE, aw_held=0, w_held=0, timeout counter=0.
  - While ARESETn=0, all outputs are 0: AWREADY, WREADY, BVALID, BRESP, mem_wen, mem_waddr, mem_wdata, mem_wmask.
- Output timing: all outputs are driven from registers or state decode only. There is no combinational path from any input to any output.
- States: IDLE, WRITE, WAIT, RESP.
- IDLE:
  - AWREADY = ~aw_held; WREADY = ~w_held.
  - AW handshake (AWVALID & AWREADY): latch AWADDR into mem_waddr, set aw_held.
  - W handshake: latch WDATA and WSTRB, set w_held.
  - Both handshakes in the same cycle: both are captured.
  - On the edge where both held flags are true (or become true):
    - Legal strobe -> WRITE.
    - Illegal strobe -> RESP with BRESP=SLVERR, and no memory write.
- Legal strobes: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Every other value, including 0000, is illegal.
- WRITE:
  - mem_wen=1 for exactly one cycle.
  - mem_waddr, mem_wdata and mem_wmask are stable during this cycle.
  - Next state: WAIT. The timeout counter clears.
- WAIT:
  - mem_wen=0; the counter increments each cycle.
  - mem_wdone=1 -> RESP, BRESP=OKAY.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> RESP, BRESP=SLVERR.
  - If both are true in the same cycle, mem_wdone wins (OKAY).
- RESP:
  - BVALID=1; BRESP is held stable until the handshake.
  - On BVALID&BREADY: go to IDLE, clear both held flags, BVALID=0 on the next cycle.
  - AWREADY=WREADY=0 throughout.
- mem_wdone outside WAIT is ignored.
- Latency with BREADY tied high and both handshakes in cycle 0:
  - mem_wen in cycle 1.
  - mem_wdone in cycle 2.
  - BVALID in cycle 3.
  - AWREADY/WREADY back high in cycle 4.
- No pipelining: at most one transaction is outstanding.
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0. The in-flight transaction is dropped and no response is issued.

Test Plan:
- Simultaneous AW(0x8000_0010)/W(0xDEADBEEF, WSTRB=1111), memory model returns wdone 1 cycle later, BREADY=1 -> mem_wen pulses once in cycle 1 with waddr=0x8000_0010, wdata=0xDEADBEEF, wmask=0x0F; BVALID in cycle 3 with BRESP=00.
- W first (WSTRB=0100) then AW 3 cycles later -> WREADY drops after the W handshake while AWREADY stays 1; exactly one mem_wen with wmask=0x04 after the AW handshake; OKAY response.
- WSTRB=0101 -> no mem_wen at any time; BVALID with BRESP=10; the bridge accepts the next transaction afterwards.
- BREADY held low 5 cycles in RESP -> BVALID and BRESP stable for all 5 cycles; AWREADY=WREADY=0; single handshake, then return to IDLE.
- TIMEOUT=4, memory model never asserts wdone -> BRESP=10 exactly 4 cycles after WAIT entry. With TIMEOUT=0 the bridge stays in WAIT indefinitely.
- ARESETn pulsed low during WAIT -> all outputs 0 immediately (asynchronous); no BVALID is issued; a following write completes normally.

Source files
------------

// File: rtl/axi_lite_wr_bridge.sv
// AXI4-Lite write-slave front end for the simulation memory write stage.
// Collects AW and W in any order, validates the byte strobe, issues one
// single-cycle memory write request, waits for its completion (bounded by an
// optional timeout) and returns an OKAY/SLVERR write response.
module axi_lite_wr_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [3:0]        WSTRB,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_wdone
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Counter only has to reach TIMEOUT-1; width stays >= 1 when disabled.
    localparam int unsigned        CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    // Only naturally aligned byte, halfword and word strobes are accepted.
    function automatic logic strb_legal(input logic [3:0] s);
        case (s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Next-state logic for the transaction FSM and captured request fields.
    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        cnt_d     = cnt_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;

        case (state_q)
            IDLE: begin
                if (AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    waddr_d   = AWADDR;
                end
                if (WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    if (strb_legal(wstrb_d)) begin
                        state_d = WRITE;
                    end else begin
                        // Bad strobe never reaches memory.
                        state_d = RESP;
                        bresp_d = RESP_SLVERR;
                    end
                end
            end
            WRITE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a simultaneous timeout.
                if (mem_wdone) begin
                    state_d = RESP;
                    bresp_d = RESP_OKAY;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = RESP;
                    bresp_d = RESP_SLVERR;
                end
            end
            RESP: begin
                if (BREADY) begin
                    state_d   = IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready flags are registered so that reset forces them low.
        awready_d = (state_d == IDLE) && !aw_held_d;
        wready_d  = (state_d == IDLE) && !w_held_d;
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            cnt_q     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            cnt_q     <= cnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // Outputs come straight from registers or state decode.
    always_comb begin
        AWREADY   = awready_q;
        WREADY    = wready_q;
        BVALID    = (state_q == RESP);
        BRESP     = bresp_q;
        mem_wen   = (state_q == WRITE);
        mem_waddr = waddr_q;
        mem_wdata = wdata_q;
        mem_wmask = {4'b0000, wstrb_q};
    end

endmodule

// File: tb/tb_axi_lite_wr_bridge.sv
// Self-checking bench for axi_lite_wr_bridge: a table of directed
// transactions, randomized transactions checked against a transaction-level
// model, and hand-written reset sequences. A second instance with the
// timeout disabled shares the AW/W stimulus but never sees mem_wdone.
module tb_axi_lite_wr_bridge;

    localparam int unsigned TO = 4;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b1;
    logic        rst1_n  = 1'b1;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] AWADDR  = '0;
    logic        WVALID  = 1'b0;
    logic        WREADY;
    logic [31:0] WDATA   = '0;
    logic [3:0]  WSTRB   = '0;
    logic        BVALID;
    logic        BREADY  = 1'b0;
    logic [1:0]  BRESP;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_wdone = 1'b0;

    logic        awready1, wready1, bvalid1, wen1;
    logic [1:0]  bresp1;
    logic [31:0] waddr1, wdata1;
    logic [7:0]  wmask1;

    int total = 0;
    int bad   = 0;
    int bv1_cnt  = 0;
    int wen1_cnt = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_wr_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_wdone(mem_wdone)
    );

    axi_lite_wr_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_nt (
        .ACLK(ACLK), .ARESETn(rst1_n),
        .AWVALID(AWVALID), .AWREADY(awready1), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(wready1), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(bvalid1), .BREADY(BREADY), .BRESP(bresp1),
        .mem_wen(wen1), .mem_waddr(waddr1), .mem_wdata(wdata1),
        .mem_wmask(wmask1), .mem_wdone(1'b0)
    );

    always @(negedge ACLK) begin
        if (bvalid1) bv1_cnt++;
        if (wen1) wen1_cnt++;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          done_dly;   // cycles after WAIT entry that memory answers
        int          b_dly;      // BVALID cycles before BREADY rises
        bit          exp_wen;
        logic [1:0]  exp_resp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference model.
    function automatic bit model_legal(input logic [3:0] s);
        return s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    function automatic logic [1:0] model_resp(input logic [3:0] s, input int done_dly);
        if (!model_legal(s)) return 2'b10;
        return (done_dly < int'(TO)) ? 2'b00 : 2'b10;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "/awready"}, AWREADY, 0);
        check({name, "/wready"}, WREADY, 0);
        check({name, "/bvalid"}, BVALID, 0);
        check({name, "/bresp"}, BRESP, 0);
        check({name, "/mem_wen"}, mem_wen, 0);
        check({name, "/mem_waddr"}, mem_waddr, 0);
        check({name, "/mem_wdata"}, mem_wdata, 0);
        check({name, "/mem_wmask"}, mem_wmask, 0);
    endtask

    // Runs one transaction; entered and left just after a rising edge.
    task automatic run_txn(input vec_t v, input string name);
        bit aw_done = 0, w_done = 0, resp_done = 0;
        int hs_cyc = -1, wen_cyc = -1, bv_first = -1, bv_cnt = 0, wen_cnt = 0;
        int exp_lat;
        AWADDR = v.addr;
        WDATA  = v.data;
        WSTRB  = v.strb;
        for (int c = 0; c < 100 && !resp_done; c++) begin
            AWVALID   = !aw_done && (c >= v.aw_dly);
            WVALID    = !w_done && (c >= v.w_dly);
            BREADY    = (bv_cnt >= v.b_dly);
            mem_wdone = (wen_cyc >= 0) && (c == wen_cyc + 1 + v.done_dly);
            @(negedge ACLK);
            if (!(aw_done && w_done)) begin
                check({name, "/awready"}, AWREADY, !aw_done);
                check({name, "/wready"}, WREADY, !w_done);
                if (AWVALID && AWREADY) aw_done = 1;
                if (WVALID && WREADY) w_done = 1;
                if (aw_done && w_done) hs_cyc = c;
            end
            if (mem_wen) begin
                wen_cnt++;
                if (wen_cyc < 0) wen_cyc = c;
                check({name, "/waddr"}, mem_waddr, v.addr);
                check({name, "/wdata"}, mem_wdata, v.data);
                check({name, "/wmask"}, mem_wmask, {4'b0000, v.strb});
            end
            if (BVALID) begin
                if (bv_first < 0) bv_first = c;
                bv_cnt++;
                check({name, "/bresp"}, BRESP, v.exp_resp);
                check({name, "/resp_awready"}, AWREADY, 0);
                check({name, "/resp_wready"}, WREADY, 0);
                if (BREADY) resp_done = 1;
            end
            if (!resp_done) begin
                @(posedge ACLK);
                #1;
            end
        end
        check({name, "/responded"}, resp_done, 1);
        check({name, "/wen_count"}, wen_cnt, v.exp_wen);
        if (v.exp_wen) begin
            exp_lat = 1 + ((v.done_dly < int'(TO)) ? v.done_dly + 1 : int'(TO));
            check({name, "/wen_latency"}, wen_cyc - hs_cyc, 1);
            check({name, "/resp_latency"}, bv_first - wen_cyc, exp_lat);
        end else begin
            check({name, "/resp_latency"}, bv_first - hs_cyc, 1);
        end
        check({name, "/bvalid_cycles"}, bv_cnt, v.b_dly + 1);
        @(posedge ACLK);
        #1;
        AWVALID   = 0;
        WVALID    = 0;
        BREADY    = 0;
        mem_wdone = 0;
        @(negedge ACLK);
        check({name, "/idle_awready"}, AWREADY, 1);
        check({name, "/idle_wready"}, WREADY, 1);
        check({name, "/idle_bvalid"}, BVALID, 0);
        @(posedge ACLK);
        #1;
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        //            addr          data          strb     aw w  done b  wen resp
        tbl[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0,  0, 1, 2'b00};
        tbl[1] = '{32'h0000_0100, 32'h1234_5678, 4'b0100, 3, 0, 0,  0, 1, 2'b00};
        tbl[2] = '{32'h0000_0200, 32'hCAFE_F00D, 4'b0101, 0, 0, 0,  0, 0, 2'b10};
        tbl[3] = '{32'h0000_0300, 32'hA5A5_5A5A, 4'b0011, 1, 1, 0,  5, 1, 2'b00};
        tbl[4] = '{32'h0000_0400, 32'h0BAD_0BAD, 4'b1100, 0, 0, 99, 0, 1, 2'b10};
        tbl[5] = '{32'h0000_0500, 32'h1111_2222, 4'b0000, 0, 1, 0,  0, 0, 2'b10};
        tbl[6] = '{32'h0000_0600, 32'h3333_4444, 4'b1000, 0, 2, 2,  1, 1, 2'b00};
        tbl[7] = '{32'h0000_0700, 32'h5555_6666, 4'b0001, 0, 0, 3,  0, 1, 2'b00};
        tbl[8] = '{32'h0000_0800, 32'h7777_8888, 4'b0010, 2, 0, 4,  0, 1, 2'b10};

        // Asynchronous reset: outputs must be low with no clock edge.
        #1;
        ARESETn = 0;
        rst1_n  = 0;
        #2;
        check_all_zero("reset_async");
        @(negedge ACLK);
        @(negedge ACLK);
        check_all_zero("reset_held");
        ARESETn = 1;
        rst1_n  = 1;
        @(posedge ACLK);
        #1;

        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset pulse while in WAIT drops the transaction.
        AWADDR = 32'h9000_0040;
        WDATA  = 32'hFEED_FACE;
        WSTRB  = 4'b1111;
        AWVALID = 1;
        WVALID  = 1;
        BREADY  = 1;
        @(posedge ACLK);
        #1;
        AWVALID = 0;
        WVALID  = 0;
        @(negedge ACLK);
        check("rst_mid/wen_before", mem_wen, 1);
        @(posedge ACLK);
        #3;
        ARESETn = 0;
        #1;
        check_all_zero("rst_mid");
        @(negedge ACLK);
        check("rst_mid/bvalid_held", BVALID, 0);
        ARESETn = 1;
        @(negedge ACLK);
        check("rst_mid/no_bvalid", BVALID, 0);
        #1;
        BREADY = 0;
        @(posedge ACLK);
        #1;
        run_txn(tbl[0], "after_rst");

        // Randomized transactions against the reference model.
        for (int i = 0; i < 30; i++) begin
            rv.addr     = $urandom;
            rv.data     = $urandom;
            rv.strb     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111 >> $urandom_range(0, 3);
            rv.aw_dly   = $urandom_range(0, 3);
            rv.w_dly    = $urandom_range(0, 3);
            rv.done_dly = $urandom_range(0, 5);
            rv.b_dly    = $urandom_range(0, 3);
            rv.exp_wen  = model_legal(rv.strb);
            rv.exp_resp = model_resp(rv.strb, rv.done_dly);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Timeout-disabled instance: one write, then parked in WAIT forever.
        check("no_timeout/bvalid_cycles", bv1_cnt, 0);
        check("no_timeout/wen_count", wen1_cnt, 1);
        check("no_timeout/awready", awready1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
